// File: rtl/spi_pkg.sv
// Shared SPI definitions: mode encodings, default frame width and receiver FSM states.
package spi_pkg;

  localparam logic Mode1Cpol = 1'b0;
  localparam logic Mode1Cpha = 1'b1;

  localparam int unsigned DataWDefault = 8;

  typedef enum logic {
    StIdle  = 1'b0,
    StShift = 1'b1
  } rx_state_e;

endpackage

// File: rtl/spi_slave_rx_mode1_if.sv
// Bundle of raw SPI lines and the parallel receive outputs of the mode-1 slave receiver.
interface spi_slave_rx_mode1_if
  import spi_pkg::*;
#(
  parameter int unsigned DATA_W = DataWDefault
);

  logic              In_spi_cs_n;
  logic              In_spi_sclk;
  logic              In_spi_mosi;
  logic [DATA_W-1:0] Out_rx_data;
  logic              Out_rx_valid;
  logic              Out_rx_busy;
  logic              Out_rx_abort;

  modport master (
    output In_spi_cs_n,
    output In_spi_sclk,
    output In_spi_mosi,
    input  Out_rx_data,
    input  Out_rx_valid,
    input  Out_rx_busy,
    input  Out_rx_abort
  );

  modport slave (
    input  In_spi_cs_n,
    input  In_spi_sclk,
    input  In_spi_mosi,
    output Out_rx_data,
    output Out_rx_valid,
    output Out_rx_busy,
    output Out_rx_abort
  );

endinterface

// File: rtl/spi_sync_edge.sv
// N-stage synchroniser for an asynchronous line, with one history flop for edge detection.
module spi_sync_edge #(
  parameter int unsigned STAGES    = 2,
  parameter logic        RESET_VAL = 1'b0
) (
  input  logic In_clk,
  input  logic In_rst_n,
  input  logic In_async,
  output logic Out_sync,
  output logic Out_rise,
  output logic Out_fall
);

  logic [STAGES-1:0] sync_q;
  logic              prev_q;

  always_ff @(posedge In_clk) begin
    if (!In_rst_n) begin
      sync_q <= {STAGES{RESET_VAL}};
      prev_q <= RESET_VAL;
    end else begin
      sync_q <= {sync_q[STAGES-2:0], In_async};
      prev_q <= sync_q[STAGES-1];
    end
  end

  always_comb begin
    Out_sync = sync_q[STAGES-1];
    Out_rise = ~prev_q & sync_q[STAGES-1];
    Out_fall = prev_q & ~sync_q[STAGES-1];
  end

endmodule

// File: rtl/spi_slave_rx_mode1.sv
// SPI mode-1 (CPOL=0, CPHA=1, MSB first) slave receiver: samples MOSI on falling SCLK and
// emits each completed word as a one-cycle valid strobe; early CS_N release pulses abort.
module spi_slave_rx_mode1
  import spi_pkg::*;
#(
  parameter int unsigned SYNC_STAGES = 2,
  parameter int unsigned DATA_W      = DataWDefault,
  parameter int unsigned CNT_W       = 4
) (
  input  logic                 In_clk,
  input  logic                 In_rst_n,
  spi_slave_rx_mode1_if.slave  bus
);

  logic sclk_fall, sclk_rise_unused, sclk_sync_unused;
  logic cs_rise, cs_fall, cs_sync_unused;
  logic mosi_sync, mosi_rise_unused, mosi_fall_unused;

  spi_sync_edge #(
    .STAGES    (SYNC_STAGES),
    .RESET_VAL (1'b0)
  ) u_sync_sclk (
    .In_clk   (In_clk),
    .In_rst_n (In_rst_n),
    .In_async (bus.In_spi_sclk),
    .Out_sync (sclk_sync_unused),
    .Out_rise (sclk_rise_unused),
    .Out_fall (sclk_fall)
  );

  spi_sync_edge #(
    .STAGES    (SYNC_STAGES),
    .RESET_VAL (1'b1)
  ) u_sync_cs (
    .In_clk   (In_clk),
    .In_rst_n (In_rst_n),
    .In_async (bus.In_spi_cs_n),
    .Out_sync (cs_sync_unused),
    .Out_rise (cs_rise),
    .Out_fall (cs_fall)
  );

  // Same depth as SCLK so MOSI is aligned with the detected falling edge.
  spi_sync_edge #(
    .STAGES    (SYNC_STAGES),
    .RESET_VAL (1'b0)
  ) u_sync_mosi (
    .In_clk   (In_clk),
    .In_rst_n (In_rst_n),
    .In_async (bus.In_spi_mosi),
    .Out_sync (mosi_sync),
    .Out_rise (mosi_rise_unused),
    .Out_fall (mosi_fall_unused)
  );

  rx_state_e         state_q, state_d;
  logic [DATA_W-1:0] shift_q;
  logic [CNT_W-1:0]  cnt_q;
  logic [DATA_W-1:0] rx_data_q;
  logic              valid_q;
  logic              abort_q;
  logic              busy;
  logic              word_done;

  assign word_done = (state_q == StShift) && sclk_fall && (cnt_q == CNT_W'(DATA_W - 1));

  always_ff @(posedge In_clk) begin
    if (!In_rst_n) begin
      state_q <= StIdle;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle:  if (cs_fall) state_d = StShift;
      StShift: if (cs_rise) state_d = StIdle;
    endcase
  end

  always_comb begin
    busy = (state_q == StShift);
  end

  always_ff @(posedge In_clk) begin
    if (!In_rst_n) begin
      shift_q   <= '0;
      cnt_q     <= '0;
      rx_data_q <= '0;
      valid_q   <= 1'b0;
      abort_q   <= 1'b0;
    end else begin
      valid_q <= 1'b0;
      abort_q <= 1'b0;
      unique case (state_q)
        StIdle: begin
          if (cs_fall) begin
            shift_q <= '0;
            cnt_q   <= '0;
          end
        end
        StShift: begin
          if (sclk_fall) begin
            shift_q <= {shift_q[DATA_W-2:0], mosi_sync};
            cnt_q   <= word_done ? '0 : cnt_q + 1'b1;
          end
          if (word_done) begin
            rx_data_q <= {shift_q[DATA_W-2:0], mosi_sync};
            valid_q   <= 1'b1;
          end
          // A final edge coinciding with CS release still completes the word cleanly.
          if (cs_rise && !word_done && (cnt_q != '0)) begin
            abort_q <= 1'b1;
          end
        end
      endcase
    end
  end

  assign bus.Out_rx_data  = rx_data_q;
  assign bus.Out_rx_valid = valid_q;
  assign bus.Out_rx_busy  = busy;
  assign bus.Out_rx_abort = abort_q;

endmodule

// File: tb/tb_spi_slave_rx_mode1.sv
// Directed bench for spi_slave_rx_mode1: single, back-to-back, multi-byte, abort, reset, noise.
module tb_spi_slave_rx_mode1;

  localparam int Half = 8;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  spi_slave_rx_mode1_if #(.DATA_W(8)) bus ();

  spi_slave_rx_mode1 #(
    .SYNC_STAGES (2),
    .DATA_W      (8),
    .CNT_W       (4)
  ) dut (
    .In_clk   (clk),
    .In_rst_n (rst_n),
    .bus      (bus)
  );

  int checks   = 0;
  int failures = 0;

  int         valid_cnt, abort_cnt, both_cnt, busy_hi, busy_lo;
  logic [7:0] vq[$];

  always @(negedge clk) begin
    if (rst_n) begin
      if (bus.Out_rx_valid) begin
        valid_cnt++;
        vq.push_back(bus.Out_rx_data);
      end
      if (bus.Out_rx_abort) abort_cnt++;
      if (bus.Out_rx_valid && bus.Out_rx_abort) both_cnt++;
      if (bus.Out_rx_busy) busy_hi++;
      else busy_lo++;
    end
  end

  task automatic wait_clks(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic clear_mon();
    valid_cnt = 0;
    abort_cnt = 0;
    busy_hi   = 0;
    busy_lo   = 0;
    vq.delete();
  endtask

  // Mode 1: launch on rising SCLK, slave samples on falling SCLK.
  task automatic spi_bits(input logic [7:0] b, input int first, input int last);
    for (int i = first; i <= last; i++) begin
      bus.In_spi_sclk = 1'b1;
      bus.In_spi_mosi = b[7-i];
      wait_clks(Half);
      bus.In_spi_sclk = 1'b0;
      wait_clks(Half);
    end
  endtask

  task automatic cs_start();
    bus.In_spi_cs_n = 1'b0;
    wait_clks(Half);
  endtask

  task automatic cs_end();
    wait_clks(Half);
    bus.In_spi_cs_n = 1'b1;
    wait_clks(10);
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    wait_clks(3);
    checks++; if (bus.Out_rx_data !== 8'h00) begin failures++;
      $display("FAIL reset_data got %h want 00", bus.Out_rx_data); end
    checks++; if (bus.Out_rx_valid !== 1'b0) begin failures++;
      $display("FAIL reset_valid got %b want 0", bus.Out_rx_valid); end
    checks++; if (bus.Out_rx_busy !== 1'b0) begin failures++;
      $display("FAIL reset_busy got %b want 0", bus.Out_rx_busy); end
    checks++; if (bus.Out_rx_abort !== 1'b0) begin failures++;
      $display("FAIL reset_abort got %b want 0", bus.Out_rx_abort); end
    rst_n = 1'b1;
    wait_clks(5);
  endtask

  task automatic test_single_byte();
    clear_mon();
    cs_start();
    spi_bits(8'hA5, 0, 7);
    wait_clks(Half);
    checks++; if (bus.Out_rx_busy !== 1'b1) begin failures++;
      $display("FAIL single_busy_in_frame got %b want 1", bus.Out_rx_busy); end
    cs_end();
    checks++; if (valid_cnt !== 1) begin failures++;
      $display("FAIL single_valid_count got %0d want 1", valid_cnt); end
    checks++; if (bus.Out_rx_data !== 8'hA5) begin failures++;
      $display("FAIL single_data got %h want a5", bus.Out_rx_data); end
    checks++; if (bus.Out_rx_busy !== 1'b0) begin failures++;
      $display("FAIL single_busy_after got %b want 0", bus.Out_rx_busy); end
    checks++; if (abort_cnt !== 0) begin failures++;
      $display("FAIL single_abort_count got %0d want 0", abort_cnt); end
  endtask

  task automatic test_back_to_back();
    clear_mon();
    cs_start();
    spi_bits(8'h3C, 0, 7);
    cs_end();
    checks++; if (bus.Out_rx_data !== 8'h3C) begin failures++;
      $display("FAIL b2b_first_data got %h want 3c", bus.Out_rx_data); end
    cs_start();
    spi_bits(8'hC3, 0, 3);
    checks++; if (bus.Out_rx_data !== 8'h3C) begin failures++;
      $display("FAIL b2b_hold_data got %h want 3c", bus.Out_rx_data); end
    spi_bits(8'hC3, 4, 7);
    cs_end();
    checks++; if (valid_cnt !== 2) begin failures++;
      $display("FAIL b2b_valid_count got %0d want 2", valid_cnt); end
    if (vq.size() >= 2) begin
      checks++; if (vq[0] !== 8'h3C) begin failures++;
        $display("FAIL b2b_word0 got %h want 3c", vq[0]); end
      checks++; if (vq[1] !== 8'hC3) begin failures++;
        $display("FAIL b2b_word1 got %h want c3", vq[1]); end
    end
  endtask

  task automatic test_multi_byte();
    clear_mon();
    cs_start();
    busy_lo = 0;
    spi_bits(8'hFF, 0, 7);
    spi_bits(8'h00, 0, 7);
    wait_clks(Half);
    checks++; if (busy_lo !== 0) begin failures++;
      $display("FAIL multi_busy_low_cycles got %0d want 0", busy_lo); end
    cs_end();
    checks++; if (valid_cnt !== 2) begin failures++;
      $display("FAIL multi_valid_count got %0d want 2", valid_cnt); end
    if (vq.size() >= 2) begin
      checks++; if (vq[0] !== 8'hFF) begin failures++;
        $display("FAIL multi_word0 got %h want ff", vq[0]); end
      checks++; if (vq[1] !== 8'h00) begin failures++;
        $display("FAIL multi_word1 got %h want 00", vq[1]); end
    end
    checks++; if (abort_cnt !== 0) begin failures++;
      $display("FAIL multi_abort_count got %0d want 0", abort_cnt); end
  endtask

  task automatic test_abort();
    clear_mon();
    cs_start();
    spi_bits(8'h81, 0, 4);
    cs_end();
    checks++; if (abort_cnt !== 1) begin failures++;
      $display("FAIL abort_count got %0d want 1", abort_cnt); end
    checks++; if (valid_cnt !== 0) begin failures++;
      $display("FAIL abort_valid_count got %0d want 0", valid_cnt); end
    checks++; if (bus.Out_rx_data !== 8'h00) begin failures++;
      $display("FAIL abort_data_held got %h want 00", bus.Out_rx_data); end
    checks++; if (bus.Out_rx_busy !== 1'b0) begin failures++;
      $display("FAIL abort_busy got %b want 0", bus.Out_rx_busy); end
  endtask

  task automatic test_reset_mid_frame();
    // Preload a nonzero word so the reset clearing Out_rx_data is observable.
    cs_start();
    spi_bits(8'h96, 0, 7);
    cs_end();
    clear_mon();
    cs_start();
    spi_bits(8'hE7, 0, 2);
    rst_n = 1'b0;
    wait_clks(1);
    rst_n = 1'b1;
    wait_clks(1);
    checks++; if (bus.Out_rx_data !== 8'h00) begin failures++;
      $display("FAIL rstmid_data got %h want 00", bus.Out_rx_data); end
    checks++; if (bus.Out_rx_busy !== 1'b0) begin failures++;
      $display("FAIL rstmid_busy got %b want 0", bus.Out_rx_busy); end
    checks++; if (bus.Out_rx_valid !== 1'b0 || bus.Out_rx_abort !== 1'b0) begin failures++;
      $display("FAIL rstmid_pulses got v=%b a=%b want v=0 a=0",
               bus.Out_rx_valid, bus.Out_rx_abort); end
    bus.In_spi_cs_n = 1'b1;
    wait_clks(10);
    cs_start();
    spi_bits(8'h5A, 0, 7);
    cs_end();
    checks++; if (bus.Out_rx_data !== 8'h5A) begin failures++;
      $display("FAIL rstmid_next_data got %h want 5a", bus.Out_rx_data); end
    checks++; if (valid_cnt !== 1) begin failures++;
      $display("FAIL rstmid_valid_count got %0d want 1", valid_cnt); end
    checks++; if (abort_cnt !== 0) begin failures++;
      $display("FAIL rstmid_abort_count got %0d want 0", abort_cnt); end
  endtask

  task automatic test_idle_noise();
    clear_mon();
    spi_bits(8'hB6, 0, 7);
    spi_bits(8'h4D, 0, 1);
    wait_clks(10);
    checks++; if (valid_cnt !== 0) begin failures++;
      $display("FAIL noise_valid_count got %0d want 0", valid_cnt); end
    checks++; if (abort_cnt !== 0) begin failures++;
      $display("FAIL noise_abort_count got %0d want 0", abort_cnt); end
    checks++; if (busy_hi !== 0) begin failures++;
      $display("FAIL noise_busy_cycles got %0d want 0", busy_hi); end
    checks++; if (bus.Out_rx_data !== 8'h5A) begin failures++;
      $display("FAIL noise_data_held got %h want 5a", bus.Out_rx_data); end
  endtask

  initial begin
    both_cnt        = 0;
    rst_n           = 1'b0;
    bus.In_spi_cs_n = 1'b1;
    bus.In_spi_sclk = 1'b0;
    bus.In_spi_mosi = 1'b0;
    clear_mon();
    wait_clks(2);
    test_reset();
    test_single_byte();
    test_back_to_back();
    test_multi_byte();
    test_abort();
    test_reset_mid_frame();
    test_idle_noise();
    checks++; if (both_cnt !== 0) begin failures++;
      $display("FAIL valid_abort_overlap got %0d want 0", both_cnt); end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
